line_fetch_sched: RTL and testbench
===================================

Name: line_fetch_sched

Overview:
- Per-scanline fetch scheduler for the pixel pipeline.
- Driven by the 720p timing counters (sx/sy). During active line N it fetches the pixel words for line N+1 from memory into one half of a ping-pong line buffer, while the display reads the other half.
- Issues burst read requests over a valid/ready handshake and tracks returning words, producing line-buffer write indices.
- Swaps buffer halves at end of line and flags underruns.

Parameters:
- CORDW, 11, width of sx/sy.
- HA_END, 1279, last active pixel x.
- LINE, 1359, last x on a line.
- VA_END, 719, last active line.
- SCREEN, 740, last line of frame.
- WORDS, 80, memory words per active line (16 px/word).
- BURST, 8, maximum words per request.
- ADDRW, 20, memory word-address width.

Ports:
- clk_pix  in  1  pixel clock.
- rst_pix  in  1  synchronous active-high reset.
- sx  in  CORDW  horizontal position from timing generator.
- sy  in  CORDW  vertical position from timing generator.
- enable  in  1  fetching allowed; sampled only at the line trigger.
- base_addr  in  ADDRW  frame base word address; sampled at the line-0 trigger.
- stride  in  ADDRW  words between successive lines.
- req_valid  out  1  read request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  ADDRW  burst start word address.
- req_len  out  4  burst length in words (1..BURST).
- resp_valid  in  1  one read word returned (in order).
- wr_en  out  1  line-buffer write strobe (= resp_valid while FILL/WAIT).
- wr_idx  out  8  {fill_buf, word index 0..WORDS-1}; index field 7 bits.
- disp_buf  out  1  buffer half the display reads.
- busy  out  1  fetch in progress.
- underrun  out  1  sticky; fetch incomplete at swap or trigger while busy.

Behaviour:
- Reset (rst_pix, synchronous, overrides everything):
  - state=IDLE; req_valid=0, req_addr=0, req_len=0.
  - wr_en=0, disp_buf=0, fill_buf=1, busy=0, underrun=0.
  - Counters cleared. Reset mid-fetch abandons it: late resp_valid after reset is ignored (no wr_en).
- Trigger: sx==0. next_line = (sy==SCREEN) ? 0 : sy+1.
  - The fetch starts only if next_line<=VA_END, enable=1 and state==IDLE.
  - If state!=IDLE at the trigger: set underrun and skip this line's fetch.
- Row address:
  - Trigger with next_line==0: row_addr <= base_addr.
  - Any other started fetch: row_addr <= row_addr + stride, modulo 2^ADDRW, wrapping silently.
- States:
  - IDLE: waits for the trigger. On trigger go to ISSUE with issue_cnt=0, rcv_cnt=0, busy=1.
  - ISSUE: req_valid=1.
    - req_addr = row_addr + issue_cnt.
    - req_len = min(BURST, WORDS-issue_cnt).
    - The request is transferred on a cycle where req_valid&&req_ready; then issue_cnt += req_len.
    - When issue_cnt reaches WORDS, deassert req_valid and go to WAIT.
    - req_addr and req_len are held stable while req_valid&&!req_ready; req_valid is never withdrawn before acceptance.
  - WAIT: go to IDLE (busy=0) when rcv_cnt==WORDS.
- Responses:
  - In ISSUE or WAIT, each resp_valid gives wr_en=1 the same cycle, with wr_idx={fill_buf, rcv_cnt}, then rcv_cnt++.
  - Responses may arrive while ISSUE is still in progress.
- Swap: at sx==LINE, if a fetch was started this line:
  - disp_buf <= fill_buf, fill_buf <= ~fill_buf.
  - If state!=IDLE at that cycle, set underrun and keep fetching into the now-display half.
  - A line with no fetch started does not swap.
- underrun clears only on reset.
- No combinational path from req_ready to req_valid.

Optional Feature:
- Macro: LINE_FETCH_STATS_EN.
- When defined:
  - Extra output underrun_cnt[15:0] counts underrun events, saturating at 16'hFFFF, reset 0.
  - Extra output max_lat[CORDW-1:0] holds the largest sx value at which WAIT→IDLE occurred in any line, reset 0.
- When undefined, neither port exists and the logic is absent.

Decomposition:
- Shared package video_pkg holds the timing constants (HA_END, LINE, VA_END, SCREEN), WORDS, BURST and the state enum {IDLE, ISSUE, WAIT}.
- One natural sub-module: line_fetch_req, the request issuer (issue counter, length clamp, handshake hold).
- The top level keeps the trigger, swap, response counting and flags.

Test Plan:
- req_ready=1 always, memory returns words 2 cycles after acceptance, base=0x100, stride=80.
  - Line 0 fetch (at sy=740) issues 10 requests, addr 0x100,0x108..0x148, len 8.
  - wr_idx runs {1,0}..{1,79}.
  - disp_buf=1 after sx=1359.
- req_ready toggled randomly.
  - req_addr/req_len stable while stalled.
  - Exactly 10 accepted requests per line; no underrun.
- WORDS=84, BURST=8: the last request has len=4 at addr row+80.
- Hold resp_valid off until sx=1359 passes: underrun=1 at that cycle and the fetch completes later; the next trigger while busy skips that line.
- rst_pix asserted in ISSUE at issue_cnt=24: all outputs go to reset values next cycle, and a subsequent resp_valid gives no wr_en.
- enable=0 at trigger: no requests and disp_buf is unchanged at line end; sy 719→720 gives no fetch for line 720.

Source files
------------

// File: rtl/video_pkg.sv
// Shared 720p timing constants, line-fetch sizing and the fetch state encoding.
package video_pkg;
  localparam int CORDW  = 11;
  localparam int HA_END = 1279;
  localparam int LINE   = 1359;
  localparam int VA_END = 719;
  localparam int SCREEN = 740;
  localparam int WORDS  = 80;
  localparam int BURST  = 8;
  localparam int ADDRW  = 20;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} fetch_state_e;
endpackage

// File: rtl/line_fetch_if.sv
// Burst read request / in-order word return channel between scheduler and memory.
interface line_fetch_if #(parameter int ADDRW = video_pkg::ADDRW);
  logic             req_valid;
  logic             req_ready;
  logic [ADDRW-1:0] req_addr;
  logic [3:0]       req_len;
  logic             resp_valid;

  modport master (output req_valid, req_addr, req_len, input req_ready, resp_valid);
  modport slave  (input req_valid, req_addr, req_len, output req_ready, resp_valid);
endinterface

// File: rtl/line_fetch_req.sv
// Burst request issuer: walks the line in BURST-sized chunks, clamping the last one.
module line_fetch_req
  import video_pkg::*;
#(
  parameter int WORDS = video_pkg::WORDS,
  parameter int BURST = video_pkg::BURST,
  parameter int ADDRW = video_pkg::ADDRW
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             start,
  input  logic             active,
  input  logic             req_ready,
  input  logic [ADDRW-1:0] row_addr,
  output logic [ADDRW-1:0] req_addr,
  output logic [3:0]       req_len,
  output logic             last_accept
);
  localparam int CW = $clog2(WORDS + 1);

  logic [CW-1:0] issue_cnt, remain, len_w;

  // Address and length come only from registers, so they hold while stalled.
  assign remain      = CW'(WORDS) - issue_cnt;
  assign len_w       = (remain > CW'(BURST)) ? CW'(BURST) : remain;
  assign last_accept = active && req_ready && ((issue_cnt + len_w) == CW'(WORDS));
  assign req_addr    = active ? row_addr + ADDRW'(issue_cnt) : '0;
  assign req_len     = active ? len_w[3:0] : '0;

  always_ff @(posedge clk_pix) begin
    if (rst_pix || start)        issue_cnt <= '0;
    else if (active && req_ready) issue_cnt <= issue_cnt + len_w;
  end
endmodule

// File: rtl/line_fetch_sched.sv
// Per-scanline ping-pong line-buffer fetch scheduler.
// Optional stats (underrun_cnt, max_lat) enabled by defining LINE_FETCH_STATS_EN.
module line_fetch_sched
  import video_pkg::*;
#(
  parameter int CORDW  = video_pkg::CORDW,
  parameter int LINE   = video_pkg::LINE,
  parameter int VA_END = video_pkg::VA_END,
  parameter int SCREEN = video_pkg::SCREEN,
  parameter int WORDS  = video_pkg::WORDS,
  parameter int BURST  = video_pkg::BURST,
  parameter int ADDRW  = video_pkg::ADDRW
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             enable,
  input  logic [ADDRW-1:0] base_addr,
  input  logic [ADDRW-1:0] stride,
  line_fetch_if.master     mem,
  output logic             wr_en,
  output logic [7:0]       wr_idx,
  output logic             disp_buf,
  output logic             busy,
  output logic             underrun
`ifdef LINE_FETCH_STATS_EN
  ,
  output logic [15:0]      underrun_cnt,
  output logic [CORDW-1:0] max_lat
`endif
);
  fetch_state_e     state, state_nxt;
  logic [CORDW-1:0] next_line;
  logic [ADDRW-1:0] row_addr;
  logic [6:0]       rcv_cnt;
  logic             trig, start, swap, uflow, fetch_done, resp_ok, last_accept;
  logic             fill_buf, wr_buf, line_started;

  assign trig       = (sx == '0);
  assign next_line  = (sy == CORDW'(SCREEN)) ? '0 : sy + CORDW'(1);
  assign start      = trig && (state == IDLE) && enable && (next_line <= CORDW'(VA_END));
  assign swap       = (sx == CORDW'(LINE)) && line_started;
  assign uflow      = (trig || swap) && (state != IDLE);
  assign fetch_done = (state == WAIT) && (rcv_cnt == 7'(WORDS));
  assign resp_ok    = mem.resp_valid && (state != IDLE);

  assign wr_en         = resp_ok;
  assign wr_idx        = {wr_buf, rcv_cnt};
  assign busy          = (state != IDLE);
  assign mem.req_valid = (state == ISSUE);

  line_fetch_req #(.WORDS(WORDS), .BURST(BURST), .ADDRW(ADDRW)) u_req (
    .clk_pix     (clk_pix),
    .rst_pix     (rst_pix),
    .start       (start),
    .active      (state == ISSUE),
    .req_ready   (mem.req_ready),
    .row_addr    (row_addr),
    .req_addr    (mem.req_addr),
    .req_len     (mem.req_len),
    .last_accept (last_accept)
  );

  always_ff @(posedge clk_pix) begin
    if (rst_pix) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)       state_nxt = ISSUE;
      ISSUE:   if (last_accept) state_nxt = WAIT;
      WAIT:    if (fetch_done)  state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // wr_buf latches the fill half at start so a late fetch keeps its target after a swap.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      row_addr     <= '0;
      rcv_cnt      <= '0;
      fill_buf     <= 1'b1;
      wr_buf       <= 1'b1;
      disp_buf     <= 1'b0;
      underrun     <= 1'b0;
      line_started <= 1'b0;
    end else begin
      if (start) begin
        row_addr     <= (next_line == '0) ? base_addr : row_addr + stride;
        rcv_cnt      <= '0;
        wr_buf       <= fill_buf;
        line_started <= 1'b1;
      end else if (resp_ok) begin
        rcv_cnt <= rcv_cnt + 7'd1;
      end
      if (swap) begin
        disp_buf     <= fill_buf;
        fill_buf     <= ~fill_buf;
        line_started <= 1'b0;
      end
      if (uflow) underrun <= 1'b1;
    end
  end

`ifdef LINE_FETCH_STATS_EN
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      underrun_cnt <= '0;
      max_lat      <= '0;
    end else begin
      if (uflow && (underrun_cnt != 16'hFFFF)) underrun_cnt <= underrun_cnt + 16'd1;
      if (fetch_done && (sx > max_lat))        max_lat      <= sx;
    end
  end
`endif
endmodule

// File: tb/tb_line_fetch_sched.sv
// Directed bench for line_fetch_sched with a 2-cycle-latency in-order memory model.
module tb_line_fetch_sched;
  logic        clk_pix = 1'b0;
  logic        rst_pix;
  logic [10:0] sx, sy;
  logic        enable;
  logic [19:0] base_addr, stride;
  logic        wr_en, disp_buf, busy, underrun;
  logic [7:0]  wr_idx;
  logic        wr_en2, disp_buf2, busy2, underrun2;
  logic [7:0]  wr_idx2;
`ifdef LINE_FETCH_STATS_EN
  logic [15:0] ucnt, ucnt2;
  logic [10:0] mlat, mlat2;
`endif

  line_fetch_if #(.ADDRW(20)) m ();
  line_fetch_if #(.ADDRW(20)) m2 ();

  always #5 clk_pix = ~clk_pix;

  line_fetch_sched dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy), .enable(enable),
    .base_addr(base_addr), .stride(stride), .mem(m), .wr_en(wr_en), .wr_idx(wr_idx),
    .disp_buf(disp_buf), .busy(busy), .underrun(underrun)
`ifdef LINE_FETCH_STATS_EN
    , .underrun_cnt(ucnt), .max_lat(mlat)
`endif
  );

  line_fetch_sched #(.WORDS(84), .BURST(8)) dut84 (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy), .enable(enable),
    .base_addr(base_addr), .stride(stride), .mem(m2), .wr_en(wr_en2), .wr_idx(wr_idx2),
    .disp_buf(disp_buf2), .busy(busy2), .underrun(underrun2)
`ifdef LINE_FETCH_STATS_EN
    , .underrun_cnt(ucnt2), .max_lat(mlat2)
`endif
  );

  int          tests = 0, fails = 0;
  int          mcyc = 0, stall_err = 0, stall_cnt = 0;
  int          q[$];
  logic [19:0] acc_addr[$], acc2_addr[$];
  logic [3:0]  acc_len[$], acc2_len[$];
  logic [7:0]  wr_q[$];
  bit          resp_en = 1'b1, rnd_ready = 1'b0;
  logic        stall_prev = 1'b0;
  logic [19:0] p_addr;
  logic [3:0]  p_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    acc_addr.delete(); acc_len.delete(); wr_q.delete();
    stall_err = 0; stall_cnt = 0;
  endtask

  task automatic step(input int x, input int y);
    @(negedge clk_pix);
    sx = 11'(x);
    sy = 11'(y);
    if (rnd_ready) m.req_ready = (x > 2) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic run_line(input int y);
    for (int x = 0; x <= 1359; x++) step(x, y);
    @(posedge clk_pix); #1;
  endtask

  // Memory: each accepted word is returned in order, first one 2 cycles after acceptance.
  initial begin
    m.resp_valid  = 1'b0;
    m2.resp_valid = 1'b0;
    m2.req_ready  = 1'b1;
    forever begin
      @(negedge clk_pix);
      mcyc++;
      if (resp_en && q.size() > 0 && q[0] <= mcyc) begin
        m.resp_valid = 1'b1;
        void'(q.pop_front());
      end else begin
        m.resp_valid = 1'b0;
      end
      #3;
      if (m.req_valid && m.req_ready) begin
        acc_addr.push_back(m.req_addr);
        acc_len.push_back(m.req_len);
        for (int i = 0; i < int'(m.req_len); i++) q.push_back(mcyc + 2);
      end
      if (m2.req_valid && m2.req_ready) begin
        acc2_addr.push_back(m2.req_addr);
        acc2_len.push_back(m2.req_len);
      end
      if (wr_en) wr_q.push_back(wr_idx);
      if (stall_prev && (!m.req_valid || m.req_addr != p_addr || m.req_len != p_len)) stall_err++;
      stall_prev = m.req_valid && !m.req_ready;
      if (stall_prev) stall_cnt++;
      p_addr = m.req_addr;
      p_len  = m.req_len;
    end
  end

  initial begin
    rst_pix = 1'b1; sx = 11'd5; sy = 11'd0; enable = 1'b1;
    base_addr = 20'h100; stride = 20'd80; m.req_ready = 1'b1;
    repeat (3) @(negedge clk_pix);
    @(posedge clk_pix); #1;
    chk("rst_req_valid", m.req_valid, 0);
    chk("rst_req_addr", m.req_addr, 0);
    chk("rst_req_len", m.req_len, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_disp_buf", disp_buf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    @(negedge clk_pix); rst_pix = 1'b0;

    // Line 0 fetch from the last frame line, ready always high.
    clear_logs(); acc2_addr.delete(); acc2_len.delete();
    run_line(740);
    chk("l0_req_count", acc_addr.size(), 10);
    chk("l0_addr0", acc_addr[0], 20'h100);
    chk("l0_addr1", acc_addr[1], 20'h108);
    chk("l0_addr9", acc_addr[9], 20'h148);
    chk("l0_len0", acc_len[0], 8);
    chk("l0_len9", acc_len[9], 8);
    chk("l0_wr_count", wr_q.size(), 80);
    chk("l0_wr_first", wr_q[0], 8'h80);
    chk("l0_wr_last", wr_q[79], 8'hCF);
    chk("l0_disp_buf", disp_buf, 1);
    chk("l0_busy", busy, 0);
    chk("l0_underrun", underrun, 0);
    chk("w84_req_count", acc2_addr.size(), 11);
    chk("w84_len9", acc2_len[9], 8);
    chk("w84_last_addr", acc2_addr[10], 20'h150);
    chk("w84_last_len", acc2_len[10], 4);

    // Line 1 with random ready: requests must hold while stalled.
    clear_logs(); rnd_ready = 1'b1;
    run_line(0);
    rnd_ready = 1'b0; m.req_ready = 1'b1;
    chk("rnd_req_count", acc_addr.size(), 10);
    chk("rnd_addr0", acc_addr[0], 20'h150);
    chk("rnd_addr9", acc_addr[9], 20'h198);
    chk("rnd_stalled", stall_cnt > 0, 1);
    chk("rnd_hold", stall_err, 0);
    chk("rnd_wr_first", wr_q[0], 8'h00);
    chk("rnd_wr_last", wr_q[79], 8'h4F);
    chk("rnd_underrun", underrun, 0);
    chk("rnd_disp_buf", disp_buf, 0);

    // Responses withheld past end of line: underrun at the swap.
    clear_logs(); resp_en = 1'b0;
    for (int x = 0; x < 1359; x++) step(x, 1);
    @(posedge clk_pix); #1;
    chk("ur_before_swap", underrun, 0);
    chk("ur_busy", busy, 1);
    chk("ur_req_count", acc_addr.size(), 10);
    chk("ur_addr0", acc_addr[0], 20'h1A0);
    step(1359, 1);
    @(posedge clk_pix); #1;
    chk("ur_at_swap", underrun, 1);
    chk("ur_disp_buf", disp_buf, 1);

    // Next trigger while busy: skipped, late words land in the old fill half.
    clear_logs(); resp_en = 1'b1;
    run_line(2);
    chk("skip_req_count", acc_addr.size(), 0);
    chk("skip_wr_count", wr_q.size(), 80);
    chk("skip_wr_first", wr_q[0], 8'h80);
    chk("skip_wr_last", wr_q[79], 8'hCF);
    chk("skip_busy", busy, 0);
    chk("skip_disp_buf", disp_buf, 1);
    chk("skip_underrun", underrun, 1);

    // Reset in ISSUE after three accepted bursts.
    clear_logs();
    for (int x = 0; x < 4; x++) step(x, 3);
    @(posedge clk_pix); #1;
    chk("mid_req_valid", m.req_valid, 1);
    chk("mid_req_addr", m.req_addr, 20'h208);
    chk("mid_req_count", acc_addr.size(), 3);
    @(negedge clk_pix); rst_pix = 1'b1; sx = 11'd4;
    @(posedge clk_pix); #1;
    chk("mrst_req_valid", m.req_valid, 0);
    chk("mrst_req_addr", m.req_addr, 0);
    chk("mrst_req_len", m.req_len, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_disp_buf", disp_buf, 0);
    chk("mrst_underrun", underrun, 0);
    @(negedge clk_pix); rst_pix = 1'b0; sx = 11'd5;
    #2;
    chk("late_resp_seen", m.resp_valid, 1);
    chk("late_resp_wr_en", wr_en, 0);
    q.delete();
    repeat (3) @(negedge clk_pix);

    // enable low at trigger, then the no-fetch line after the last active line.
    clear_logs(); enable = 1'b0;
    run_line(740);
    chk("dis_req_count", acc_addr.size(), 0);
    chk("dis_disp_buf", disp_buf, 0);
    enable = 1'b1;
    run_line(719);
    chk("va_end_req_count", acc_addr.size(), 0);
    chk("va_end_disp_buf", disp_buf, 0);
    chk("va_end_busy", busy, 0);

    // New base sampled at the line-0 trigger.
    clear_logs(); base_addr = 20'h3000;
    run_line(740);
    chk("nb_req_count", acc_addr.size(), 10);
    chk("nb_addr0", acc_addr[0], 20'h3000);
    chk("nb_addr9", acc_addr[9], 20'h3048);
    chk("nb_wr_first", wr_q[0], 8'h80);
    chk("nb_disp_buf", disp_buf, 1);
    chk("nb_underrun", underrun, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
